// File: rtl/cond_eval_unit.sv
// ---------------------------------------------------------------------------
// cond_eval_unit
//
// Holds the architectural flag register and evaluates a stream of tagged
// branch-condition requests. Results are queued in a small in-order FIFO for
// the fetch/PC-update stage. A saturating counter tracks how many taken
// results the consumer has popped.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset (priority over everything)
//   flag_we     load flag register this cycle
//   flag_wdata  new flags, [3]=Z [2]=C [1]=N [0]=V
//   req_valid   request present
//   req_ready   unit can accept a request (combinational)
//   req_cond    4-bit condition code
//   req_tag     request identifier, carried to the result
//   res_valid   FIFO head valid
//   res_ready   consumer takes the head
//   res_taken   head result, 1 = condition passed
//   res_tag     head tag
//   flush       discard buffered and same-cycle requests
//   flags_q     current flag register
//   fifo_count  number of buffered results
//   taken_cnt   saturating count of popped taken results
// ---------------------------------------------------------------------------
module cond_eval_unit #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 16,
    parameter int NV_TAKEN = 0,
    parameter int FWD_EN   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flag_we,
    input  logic [3:0]                 flag_wdata,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_cond,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_taken,
    output logic [TAG_W-1:0]           res_tag,
    input  logic                       flush,
    output logic [3:0]                 flags_q,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           taken_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Condition table evaluated against a [Z,C,N,V] flag vector.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic z, c, n, v;
        z = f[3];
        c = f[2];
        n = f[1];
        v = f[0];
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return (NV_TAKEN != 0);
        endcase
    endfunction

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             mem_taken [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];

    logic             full;
    logic             push, pop;
    logic [3:0]       eff_flags;
    logic             new_taken;
    logic             head_from_req;
    logic             head_taken_nxt;
    logic [TAG_W-1:0] head_tag_nxt;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        full           = 1'b0;
        req_ready      = 1'b0;
        eff_flags      = flags_q;
        new_taken      = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        rd_ptr_nxt     = rd_ptr;
        wr_ptr_nxt     = wr_ptr;
        count_nxt      = fifo_count;
        head_from_req  = 1'b0;
        head_taken_nxt = 1'b0;
        head_tag_nxt   = '0;

        full      = (fifo_count == CW'(DEPTH));
        // A full FIFO still accepts when the head leaves in the same cycle.
        req_ready = !rst && (!full || res_ready);

        if (FWD_EN != 0 && flag_we)
            eff_flags = flag_wdata;
        new_taken = cond_pass(req_cond, eff_flags);

        push = req_valid && req_ready && !flush;
        pop  = res_valid && res_ready && !flush;

        if (pop)
            rd_ptr_nxt = rd_ptr + 1'b1;
        if (push)
            wr_ptr_nxt = wr_ptr + 1'b1;

        case ({push, pop})
            2'b10:   count_nxt = fifo_count + CW'(1);
            2'b01:   count_nxt = fifo_count - CW'(1);
            default: count_nxt = fifo_count;
        endcase

        // The incoming entry becomes the next head only when the FIFO is
        // empty after this cycle's pop; storage is bypassed in that case.
        head_from_req  = push && (wr_ptr == rd_ptr_nxt);
        head_taken_nxt = head_from_req ? new_taken : mem_taken[rd_ptr_nxt];
        head_tag_nxt   = head_from_req ? req_tag   : mem_tag[rd_ptr_nxt];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            res_tag    <= '0;
            taken_cnt  <= '0;
        end else begin
            if (flag_we)
                flags_q <= flag_wdata;

            if (pop && res_taken && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + 1'b1;

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                res_valid  <= 1'b0;
            end else begin
                wr_ptr     <= wr_ptr_nxt;
                rd_ptr     <= rd_ptr_nxt;
                fifo_count <= count_nxt;
                res_valid  <= (count_nxt != '0);
                // Head registers hold their value while nothing changes, so
                // the output stays stable during back-pressure.
                if (count_nxt != '0) begin
                    res_taken <= head_taken_nxt;
                    res_tag   <= head_tag_nxt;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_taken[wr_ptr] <= new_taken;
            mem_tag[wr_ptr]   <= req_tag;
        end
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// ---------------------------------------------------------------------------
// Bench for cond_eval_unit. Two instances share one stimulus stream:
//   u_main : DEPTH=4, CNT_W=16, NV_TAKEN=0, FWD_EN=1
//   u_alt  : DEPTH=4, CNT_W=2,  NV_TAKEN=1, FWD_EN=0
// Both have identical occupancy for identical inputs; only results and the
// counter width differ. A queue-based model is compared every cycle on the
// falling edge, alongside directed literal checks.
// ---------------------------------------------------------------------------
module tb_cond_eval_unit;

    logic       clk;
    logic       rst;
    logic       flag_we;
    logic [3:0] flag_wdata;
    logic       req_valid;
    logic [3:0] req_cond;
    logic [3:0] req_tag;
    logic       res_ready;
    logic       flush;

    logic       req_ready0, res_valid0, res_taken0;
    logic [3:0] res_tag0, flags_q0;
    logic [2:0] fifo_count0;
    logic [15:0] taken_cnt0;

    logic       req_ready1, res_valid1, res_taken1;
    logic [3:0] res_tag1, flags_q1;
    logic [2:0] fifo_count1;
    logic [1:0] taken_cnt1;

    int errors = 0;
    int checks = 0;

    cond_eval_unit #(
        .DEPTH(4), .TAG_W(4), .CNT_W(16), .NV_TAKEN(0), .FWD_EN(1)
    ) u_main (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_wdata(flag_wdata),
        .req_valid(req_valid), .req_ready(req_ready0), .req_cond(req_cond),
        .req_tag(req_tag), .res_valid(res_valid0), .res_ready(res_ready),
        .res_taken(res_taken0), .res_tag(res_tag0), .flush(flush),
        .flags_q(flags_q0), .fifo_count(fifo_count0), .taken_cnt(taken_cnt0)
    );

    cond_eval_unit #(
        .DEPTH(4), .TAG_W(4), .CNT_W(2), .NV_TAKEN(1), .FWD_EN(0)
    ) u_alt (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_wdata(flag_wdata),
        .req_valid(req_valid), .req_ready(req_ready1), .req_cond(req_cond),
        .req_tag(req_tag), .res_valid(res_valid1), .res_ready(res_ready),
        .res_taken(res_taken1), .res_tag(res_tag1), .flush(flush),
        .flags_q(flags_q1), .fifo_count(fifo_count1), .taken_cnt(taken_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Conditions come in complementary pairs: odd codes invert the even code
    // below them, except the E/F pair (always / NV behaviour).
    function automatic bit m_eval(input logic [3:0] f, input logic [3:0] c, input bit nv);
        bit z, cy, n, v, base;
        z = f[3]; cy = f[2]; n = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] ? nv : 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    typedef struct packed {
        logic       tk0;
        logic       tk1;
        logic [3:0] tag;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] mflags;
    int         mcnt0, mcnt1;
    bit         live = 0;

    always @(posedge clk) begin
        ent_t e;
        bit   acc, pp;
        if (rst) begin
            mq.delete();
            mflags = 4'h0;
            mcnt0  = 0;
            mcnt1  = 0;
            live   = 1;
        end else if (live) begin
            acc = req_valid && (mq.size() < 4 || res_ready) && !flush;
            pp  = (mq.size() > 0) && res_ready && !flush;
            e.tk0 = m_eval(flag_we ? flag_wdata : mflags, req_cond, 1'b0);
            e.tk1 = m_eval(mflags, req_cond, 1'b1);
            e.tag = req_tag;
            if (flush) begin
                mq.delete();
            end else begin
                if (pp) begin
                    ent_t h;
                    h = mq.pop_front();
                    if (h.tk0 && mcnt0 < 65535) mcnt0++;
                    if (h.tk1 && mcnt1 < 3)     mcnt1++;
                end
                if (acc) mq.push_back(e);
            end
            if (flag_we) mflags = flag_wdata;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("cmp_req_ready0", req_ready0, !rst && (mq.size() < 4 || res_ready));
            check("cmp_req_ready1", req_ready1, !rst && (mq.size() < 4 || res_ready));
            check("cmp_valid0", res_valid0, mq.size() != 0);
            check("cmp_valid1", res_valid1, mq.size() != 0);
            check("cmp_count0", fifo_count0, mq.size());
            check("cmp_count1", fifo_count1, mq.size());
            check("cmp_flags0", flags_q0, mflags);
            check("cmp_flags1", flags_q1, mflags);
            check("cmp_cnt0", taken_cnt0, mcnt0);
            check("cmp_cnt1", taken_cnt1, mcnt1);
            if (mq.size() != 0) begin
                check("cmp_taken0", res_taken0, mq[0].tk0);
                check("cmp_taken1", res_taken1, mq[0].tk1);
                check("cmp_tag0", res_tag0, mq[0].tag);
                check("cmp_tag1", res_tag1, mq[0].tag);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rst = 0; flag_we = 0; flag_wdata = 0; req_valid = 0;
        req_cond = 0; req_tag = 0; res_ready = 0; flush = 0;
    endtask

    task automatic check_reset_state();
        check("rst_ready0", req_ready0, 0);
        check("rst_flags0", flags_q0, 0);
        check("rst_count0", fifo_count0, 0);
        check("rst_valid0", res_valid0, 0);
        check("rst_taken0", res_taken0, 0);
        check("rst_tag0", res_tag0, 0);
        check("rst_cnt0", taken_cnt0, 0);
        check("rst_valid1", res_valid1, 0);
        check("rst_cnt1", taken_cnt1, 0);
    endtask

    logic [3:0] grp_cond [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'hE};
    logic       grp_e0   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       grp_e1   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int         sat_exp  [5] = '{1, 2, 3, 3, 3};

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        check_reset_state();
        rst = 0;

        // Z=1, then EQ / NE in order, head valid one cycle after accept
        flag_we = 1; flag_wdata = 4'b1000; tick(); flag_we = 0;
        check("z_flags", flags_q0, 4'b1000);
        check("pre_valid", res_valid0, 0);
        req_valid = 1; req_cond = 4'h0; req_tag = 4'd1; tick();
        check("eq_valid", res_valid0, 1);
        check("eq_taken", res_taken0, 1);
        check("eq_tag", res_tag0, 1);
        req_cond = 4'h1; req_tag = 4'd2; tick(); req_valid = 0;
        check("two_count", fifo_count0, 2);
        check("hold_tag", res_tag0, 1);
        res_ready = 1; tick();
        check("ne_taken", res_taken0, 0);
        check("ne_tag", res_tag0, 2);
        tick();
        check("drained", res_valid0, 0);
        res_ready = 0;

        // forwarding: flags_q=0, write N=1 together with MI
        flag_we = 1; flag_wdata = 4'b0000; tick();
        flag_wdata = 4'b0010; req_valid = 1; req_cond = 4'h4; req_tag = 4'd3; tick();
        flag_we = 0; req_valid = 0;
        check("fwd_on", res_taken0, 1);
        check("fwd_off", res_taken1, 0);
        res_ready = 1; tick(); res_ready = 0;
        check("cnt_after_fwd0", taken_cnt0, 2);
        check("cnt_after_fwd1", taken_cnt1, 1);

        // fill, then streaming push+pop across pointer wrap
        for (int k = 0; k < 4; k++) begin
            req_valid = 1; req_cond = 4'hE; req_tag = 4'(4 + k); tick();
        end
        req_valid = 0;
        check("full_count", fifo_count0, 4);
        check("full_ready", req_ready0, 0);
        res_ready = 1; req_valid = 1;
        for (int k = 0; k < 6; k++) begin
            req_tag = 4'(8 + k); tick();
            check("stream_tag", res_tag0, 5 + k);
            check("stream_count", fifo_count0, 4);
        end
        req_valid = 0;
        repeat (4) tick();
        check("stream_drained", res_valid0, 0);
        res_ready = 0;

        // signed conditions with N=1, V=0, Z=0; NV / AL
        flag_we = 1; flag_wdata = 4'b0010; tick(); flag_we = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1; req_cond = grp_cond[i]; req_tag = 4'(i); tick();
            req_valid = 0;
            check("grp_taken0", res_taken0, grp_e0[i]);
            check("grp_taken1", res_taken1, grp_e1[i]);
            res_ready = 1; tick(); res_ready = 0;
        end

        // flush with same-cycle request and flag write
        for (int k = 0; k < 3; k++) begin
            req_valid = 1; req_cond = 4'hE; req_tag = 4'(k); tick();
        end
        req_tag = 4'd15; flush = 1; flag_we = 1; flag_wdata = 4'b0100; tick();
        flush = 0; flag_we = 0; req_valid = 0;
        check("flush_count", fifo_count0, 0);
        check("flush_valid", res_valid0, 0);
        check("flush_flags", flags_q0, 4'b0100);
        res_ready = 1;
        repeat (3) begin
            tick();
            check("flush_dropped", res_valid0, 0);
        end
        res_ready = 0;

        // counter saturation on the 2-bit instance
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1; req_cond = 4'hE; req_tag = 4'(k); tick();
            req_valid = 0; res_ready = 1; tick(); res_ready = 0;
            check("sat_cnt1", taken_cnt1, sat_exp[k]);
            check("sat_cnt0", taken_cnt0, k + 1);
        end

        // reset mid-stream
        flag_we = 1; flag_wdata = 4'hF; req_valid = 1; req_cond = 4'hE; req_tag = 4'd9; tick();
        req_tag = 4'd10; rst = 1; tick();
        check_reset_state();
        idle();
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            flag_we    = ($urandom_range(0, 3) == 0);
            flag_wdata = 4'($urandom);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_cond   = 4'($urandom);
            req_tag    = 4'($urandom);
            res_ready  = (n % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Parametrised successor to the single-shot branch condition checker.
- Holds the architectural flag register and accepts a stream of tagged condition-evaluation requests over a valid/ready handshake.
- Evaluates all 16 condition codes against the current or forwarded flags, and buffers results in a DEPTH-entry FIFO for the fetch/PC-update stage.
- Keeps a saturating taken-branch counter for performance monitoring.

Parameters:
DEPTH, 4, result FIFO entries (power of two, >=2)
TAG_W, 4, width of the request tag carried to the result
CNT_W, 16, width of the taken-branch counter
NV_TAKEN, 0, behaviour of cond 4'b1111: 0 = never taken, 1 = always taken
FWD_EN, 1, 1 = a request accepted in the same cycle as a flag write evaluates against the new flags

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flag_we  in  1  load flag register this cycle
flag_wdata  in  4  new flags [Z,C,N,V] = [3:0]
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_cond  in  4  condition code
req_tag  in  TAG_W  request identifier
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer takes head
res_taken  out  1  head result: 1 = condition passed
res_tag  out  TAG_W  head tag
flush  in  1  discard all buffered and same-cycle requests
flags_q  out  4  current flag register [Z,C,N,V]
fifo_count  out  $clog2(DEPTH)+1  entries in FIFO
taken_cnt  out  CNT_W  saturating count of taken results popped

Behaviour:
- Reset (rst=1 at edge):
  - flags_q=0, FIFO empty, fifo_count=0, res_valid=0, res_taken=0, res_tag=0, taken_cnt=0.
  - rst has priority over flag_we, flush and all handshakes.
- Flag register: on flag_we, flags_q <= flag_wdata at the next edge.
- Effective flags for evaluation:
  - FWD_EN=1: flag_wdata if flag_we is asserted, else flags_q.
  - FWD_EN=0: always flags_q.
- Condition table (Z,C,N,V):
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 MI: N.
  - 5 PL: !N.
  - 6 VS: V.
  - 7 VC: !V.
  - 8 HI: C&!Z.
  - 9 LS: !C|Z.
  - A GE: N==V.
  - B LT: N!=V.
  - C GT: !Z&(N==V).
  - D LE: Z|(N!=V).
  - E AL: 1.
  - F: NV_TAKEN.
- Handshake:
  - accept = req_valid & req_ready & !flush.
  - pop = res_valid & res_ready & !flush.
  - req_ready = !full | res_ready. Same-cycle push while full is allowed only when the head pops.
  - req_ready is forced 0 while rst=1.
- Latency:
  - A request accepted at edge k is visible as a FIFO entry after edge k.
  - If the FIFO was empty, res_valid=1 and res_taken/res_tag are valid in cycle k+1.
  - There is no combinational path from req_* to res_*.
- FIFO:
  - In-order, circular read/write pointers of $clog2(DEPTH) bits; wrap at DEPTH-1 -> 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty cannot happen (res_valid=0). Push when full without pop cannot happen (req_ready=0).
  - res_taken/res_tag are held stable while res_valid=1 and res_ready=0.
- Flush:
  - Next edge: FIFO emptied, pointers reset, res_valid=0, the same-cycle request dropped, and no pop counted.
  - flags_q still updates if flag_we is asserted; taken_cnt is retained.
- taken_cnt:
  - Increments on pop when res_taken=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Entries are never dropped without flush. Outputs are registered, except req_ready, which is combinational from full/res_ready/rst.

Test Plan:
- Reset then flag_wdata=4'b1000 (Z=1) with flag_we; next cycle issue cond 0 tag 1, cond 1 tag 2 -> results (taken=1,tag=1), (taken=0,tag=2) in order, first res_valid exactly one cycle after accept.
- FWD_EN=1: flag_we with 4'b0010 (N=1) in the same cycle as accepted cond 4 (MI) while flags_q=0 -> taken=1. With FWD_EN=0, same stimulus -> taken=0.
- res_ready=0, push DEPTH=4 requests -> fifo_count=4, req_ready=0. Then res_ready=1 with req_valid=1 for 6 cycles -> one push plus one pop per cycle, count stays 4, tags emerge in order across pointer wrap.
- Flags N=1,V=0,Z=0 -> GE=0, LT=1, GT=0, LE=1. Cond F -> 0 with NV_TAKEN=0 and 1 with NV_TAKEN=1. Cond E -> always 1.
- Fill 3 entries, assert flush together with req_valid and flag_we=4'b0100 -> next cycle fifo_count=0, res_valid=0, flags_q=4'b0100, dropped request never appears.
- CNT_W=2: pop 5 taken results -> taken_cnt reads 1,2,3,3,3. Assert rst mid-stream -> all outputs return to reset values next edge.
